jet_readout_seq: RTL and testbench

Readout sequencer directly downstream of the z-bin jet cascade. On each rising edge of the cascade's `all_done` it latches the jet count `Nmax` and walks `final_cluster_addr` from 0 to count−1. It captures each 32-bit jet word after a fixed read latency and streams the words out on a valid/ready interface through a small credit-managed FIFO. After the last word is accepted it pulses `event_done` so the cascade can release the event.

---
 rtl/jet_readout_seq.sv | 141 ++++++++++++++
 tb/tb_jet_readout_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jet_readout_seq.sv
// Readout sequencer for the z-bin jet cascade: walks the jet address space once per
// event, captures words after a fixed read latency and streams them out through a credit-managed FIFO.
module jet_readout_seq #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_JETS   = 255
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        all_done,
  input  logic [7:0]  Nmax,
  input  logic [31:0] final_cluster_out,
  output logic [7:0]  final_cluster_addr,
  output logic        event_done,
  output logic [31:0] jet_data,
  output logic        jet_valid,
  output logic        jet_last,
  output logic        jet_empty,
  input  logic        jet_ready,
  output logic        busy,
  output logic        clipped,
  output logic [15:0] evt_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  MAX_V   = 8'(MAX_JETS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic              all_done_q;
  logic [7:0]        n_jets;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [RD_LAT-1:0] rd_vld_p;
  logic [RD_LAT-1:0] rd_last_p;
  logic [31:0]       mem_data  [FIFO_DEPTH];
  logic              mem_last  [FIFO_DEPTH];
  logic              mem_empty [FIFO_DEPTH];

  logic credit_ok, issue, last_issue, zero_push, cap, push, pop;

  function automatic logic [7:0] sat_jets(input logic [7:0] n);
    return (n > MAX_V) ? MAX_V : n;
  endfunction

  assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_V;
  assign issue      = (state == ISSUE) && (n_jets != 8'd0) && credit_ok;
  assign last_issue = issue && (final_cluster_addr == n_jets - 8'd1);
  assign zero_push  = (state == ISSUE) && (n_jets == 8'd0);
  assign cap        = rd_vld_p[RD_LAT-1];
  assign push       = cap | zero_push;
  assign pop        = jet_valid & jet_ready;

  // FIFO head drives the stream; gated to zero while empty
  assign jet_valid = (fifo_count != '0);
  assign jet_data  = jet_valid ? mem_data[rd_ptr] : 32'h0;
  assign jet_last  = jet_valid & mem_last[rd_ptr];
  assign jet_empty = jet_valid & mem_empty[rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state              <= IDLE;
      all_done_q         <= 1'b0;
      n_jets             <= 8'd0;
      final_cluster_addr <= 8'd0;
      event_done         <= 1'b0;
      busy               <= 1'b0;
      clipped            <= 1'b0;
      evt_count          <= 16'd0;
    end else begin
      all_done_q <= all_done;
      event_done <= 1'b0;
      case (state)
        IDLE: if (all_done && !all_done_q) begin
          n_jets             <= sat_jets(Nmax);
          clipped            <= (Nmax > MAX_V);
          busy               <= 1'b1;
          final_cluster_addr <= 8'd0;
          state              <= ISSUE;
        end
        ISSUE: begin
          if (zero_push) state <= DRAIN;
          else if (last_issue) state <= DRAIN;
          else if (issue) final_cluster_addr <= final_cluster_addr + 8'd1;
        end
        DRAIN: if (inflight == '0 && fifo_count == '0) begin
          event_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy      <= 1'b0;
          evt_count <= evt_count + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency delay line (issue -> capture) and FIFO occupancy bookkeeping
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_vld_p   <= '0;
      rd_last_p  <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      rd_vld_p  <= (rd_vld_p << 1) | RD_LAT'(issue);
      rd_last_p <= (rd_last_p << 1) | RD_LAT'(last_issue);
      case ({issue, cap})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Capture stage: the word emerging from the cascade lands at the FIFO tail
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= zero_push ? 32'h0 : final_cluster_out;
      mem_last[wr_ptr]  <= zero_push | rd_last_p[RD_LAT-1];
      mem_empty[wr_ptr] <= zero_push;
    end
  end

endmodule

// File: tb/tb_jet_readout_seq.sv
// Directed bench for jet_readout_seq: two instances (MAX_JETS 255 and 8) fed by a
// cascade model that returns 0xA000_0000+addr two cycles after the address.
module tb_jet_readout_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb, all_done, jet_ready;
  logic [7:0]  Nmax, final_cluster_addr;
  logic [31:0] final_cluster_out, jet_data;
  logic        event_done, jet_valid, jet_last, jet_empty, busy, clipped;
  logic [15:0] evt_count;

  logic        all_done_c, jet_ready_c;
  logic [7:0]  Nmax_c, addr_c;
  logic [31:0] out_c, jet_data_c;
  logic        event_done_c, jet_valid_c, jet_last_c, jet_empty_c, busy_c, clipped_c;
  logic [15:0] evt_count_c;

  int checks = 0;
  int fails  = 0;
  logic [31:0] got_q[$];
  logic        last_q[$];

  jet_readout_seq #(.RD_LAT(2), .FIFO_DEPTH(4), .MAX_JETS(255)) dut (
    .clk(clk), .rstb(rstb), .all_done(all_done), .Nmax(Nmax),
    .final_cluster_out(final_cluster_out), .final_cluster_addr(final_cluster_addr),
    .event_done(event_done), .jet_data(jet_data), .jet_valid(jet_valid),
    .jet_last(jet_last), .jet_empty(jet_empty), .jet_ready(jet_ready),
    .busy(busy), .clipped(clipped), .evt_count(evt_count));

  jet_readout_seq #(.RD_LAT(2), .FIFO_DEPTH(4), .MAX_JETS(8)) dut_c (
    .clk(clk), .rstb(rstb), .all_done(all_done_c), .Nmax(Nmax_c),
    .final_cluster_out(out_c), .final_cluster_addr(addr_c),
    .event_done(event_done_c), .jet_data(jet_data_c), .jet_valid(jet_valid_c),
    .jet_last(jet_last_c), .jet_empty(jet_empty_c), .jet_ready(jet_ready_c),
    .busy(busy_c), .clipped(clipped_c), .evt_count(evt_count_c));

  // cascade model with a two-cycle read latency
  logic [7:0] a_d1, a_d2, c_d1, c_d2;
  always @(posedge clk) begin
    a_d1 <= final_cluster_addr; a_d2 <= a_d1;
    c_d1 <= addr_c;             c_d2 <= c_d1;
  end
  assign final_cluster_out = 32'hA000_0000 + {24'h0, a_d2};
  assign out_c             = 32'hA000_0000 + {24'h0, c_d2};

  logic [61:0] obs;
  assign obs = {final_cluster_addr, event_done, jet_valid, jet_last, jet_empty,
                busy, clipped, evt_count, jet_data};

  always @(posedge clk) begin
    if (rstb && dut.push && !dut.pop && dut.fifo_count == 3'd4) begin
      fails++; $display("FAIL overflow: push into full FIFO (dut)");
    end
    if (rstb && dut_c.push && !dut_c.pop && dut_c.fifo_count == 3'd4) begin
      fails++; $display("FAIL overflow: push into full FIFO (dut_c)");
    end
  end

  task automatic collect(input bit sel, input int budget, input int tog_at, output int ndone);
    got_q.delete(); last_q.delete(); ndone = 0;
    for (int k = 1; k <= budget && ndone == 0; k++) begin
      @(negedge clk);
      if (tog_at != 0 && k == tog_at)     all_done = 1'b0;
      if (tog_at != 0 && k == tog_at + 1) all_done = 1'b1;
      if (!sel) begin
        if (jet_valid && jet_ready) begin got_q.push_back(jet_data); last_q.push_back(jet_last); end
        if (event_done) ndone++;
      end else begin
        if (jet_valid_c && jet_ready_c) begin got_q.push_back(jet_data_c); last_q.push_back(jet_last_c); end
        if (event_done_c) ndone++;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== 62'h0) begin fails++; $display("FAIL reset_outputs: got %h want 0", obs); end
    checks++;
    if ({addr_c, event_done_c, jet_valid_c, busy_c, clipped_c, evt_count_c} !== 28'h0) begin
      fails++; $display("FAIL reset_outputs_c: got nonzero want 0");
    end
  endtask

  task automatic test_basic();
    logic [61:0] exp;
    Nmax = 8'd5; all_done = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp = {8'((k <= 5) ? k - 1 : 4), 1'(k == 10), 1'(k >= 4 && k <= 8), 1'(k == 8), 1'b0,
             1'(k <= 10), 1'b0, 16'((k >= 11) ? 1 : 0),
             (k >= 4 && k <= 8) ? 32'hA000_0000 + 32'(k - 4) : 32'h0};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL basic_cycle%0d: got %h want %h", k, obs, exp); end
      if (k == 11) all_done = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int ndone = 0;
    bit pend = 1'b0;
    logic [31:0] held = 32'h0;
    Nmax = 8'd10; all_done = 1'b1;
    for (int c = 0; c < 400 && ndone == 0; c++) begin
      @(negedge clk);
      jet_ready = (c % 4 == 0);
      if (pend) begin
        checks++;
        if (!jet_valid || jet_data !== held) begin
          fails++; $display("FAIL bp_stable: got v=%0d %h want v=1 %h", jet_valid, jet_data, held);
        end
      end
      checks++;
      if (int'(final_cluster_addr) > acc + 4) begin
        fails++; $display("FAIL bp_ahead: got addr %0d want <= %0d", final_cluster_addr, acc + 4);
      end
      if (jet_valid && jet_ready) begin
        checks++;
        if (acc >= 10 || jet_data !== 32'hA000_0000 + 32'(acc) || jet_last !== (acc == 9)) begin
          fails++; $display("FAIL bp_word%0d: got %h last=%0d want %h", acc, jet_data, jet_last, 32'hA000_0000 + 32'(acc));
        end
        acc++;
      end
      pend = jet_valid && !jet_ready; held = jet_data;
      if (event_done) ndone++;
    end
    checks++;
    if (acc != 10 || ndone != 1) begin fails++; $display("FAIL bp_count: got %0d words done=%0d want 10 done=1", acc, ndone); end
    @(negedge clk); jet_ready = 1'b1; all_done = 1'b0;
    checks++;
    if (evt_count !== 16'd2) begin fails++; $display("FAIL bp_evt_count: got %0d want 2", evt_count); end
  endtask

  task automatic test_zero();
    logic [61:0] exp;
    Nmax = 8'd0; all_done = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp = {8'h0, 1'(k == 4), 1'(k == 2), 1'(k == 2), 1'(k == 2), 1'(k <= 4), 1'b0,
             16'((k >= 5) ? 3 : 2), 32'h0};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL zero_cycle%0d: got %h want %h", k, obs, exp); end
      if (k == 5) all_done = 1'b0;
    end
  endtask

  task automatic test_clip();
    int ndone;
    Nmax_c = 8'd20; all_done_c = 1'b1;
    @(negedge clk);
    checks++;
    if (clipped_c !== 1'b1) begin fails++; $display("FAIL clip_flag: got %0d want 1", clipped_c); end
    collect(1'b1, 80, 0, ndone);
    checks++;
    if (got_q.size() != 8 || ndone != 1) begin fails++; $display("FAIL clip_count: got %0d words want 8", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 32'hA000_0000 + 32'(i) || last_q[i] !== (i == 7)) begin
        fails++; $display("FAIL clip_word%0d: got %h last=%0d want %h", i, got_q[i], last_q[i], 32'hA000_0000 + 32'(i));
      end
    end
    @(negedge clk); all_done_c = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (clipped_c !== 1'b1) begin fails++; $display("FAIL clip_sticky: got %0d want 1", clipped_c); end
    Nmax_c = 8'd3; all_done_c = 1'b1;
    @(negedge clk);
    checks++;
    if (clipped_c !== 1'b0) begin fails++; $display("FAIL clip_clear: got %0d want 0", clipped_c); end
    collect(1'b1, 60, 0, ndone);
    checks++;
    if (got_q.size() != 3 || ndone != 1 || got_q[2] !== 32'hA000_0002) begin
      fails++; $display("FAIL clip_small: got %0d words want 3", got_q.size());
    end
    @(negedge clk); all_done_c = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ndone;
    Nmax = 8'd2; jet_ready = 1'b0; all_done = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (jet_valid !== 1'b1 || jet_data !== 32'hA000_0000 || busy !== 1'b1) begin
      fails++; $display("FAIL rmid_pre: got v=%0d %h busy=%0d want v=1 a0000000 busy=1", jet_valid, jet_data, busy);
    end
    rstb = 1'b0; all_done = 1'b0;
    #1;
    checks++;
    if (obs !== 62'h0) begin fails++; $display("FAIL rmid_async: got %h want 0", obs); end
    repeat (2) @(negedge clk);
    rstb = 1'b1; jet_ready = 1'b1;
    repeat (2) @(negedge clk);
    Nmax = 8'd3; all_done = 1'b1;
    collect(1'b0, 60, 0, ndone);
    checks++;
    if (got_q.size() != 3 || ndone != 1) begin fails++; $display("FAIL rmid_count: got %0d words want 3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 32'hA000_0000 + 32'(i)) begin
        fails++; $display("FAIL rmid_word%0d: got %h want %h", i, got_q[i], 32'hA000_0000 + 32'(i));
      end
    end
    @(negedge clk); all_done = 1'b0;
    checks++;
    if (evt_count !== 16'd1) begin fails++; $display("FAIL rmid_evt_count: got %0d want 1", evt_count); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    Nmax = 8'd6; all_done = 1'b1;
    collect(1'b0, 80, 2, ndone);
    checks++;
    if (got_q.size() != 6 || ndone != 1 || last_q[5] !== 1'b1) begin
      fails++; $display("FAIL b2b_first: got %0d words want 6", got_q.size());
    end
    @(negedge clk); all_done = 1'b0;
    checks++;
    if (evt_count !== 16'd2 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_evt1: got cnt=%0d busy=%0d want cnt=2 busy=0", evt_count, busy);
    end
    repeat (2) @(negedge clk);
    @(negedge clk); Nmax = 8'd2; all_done = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || final_cluster_addr !== 8'd0) begin
      fails++; $display("FAIL b2b_latch: got busy=%0d addr=%0d want busy=1 addr=0", busy, final_cluster_addr);
    end
    collect(1'b0, 60, 0, ndone);
    checks++;
    if (got_q.size() != 2 || ndone != 1 || got_q[1] !== 32'hA000_0001) begin
      fails++; $display("FAIL b2b_second: got %0d words want 2", got_q.size());
    end
    @(negedge clk); all_done = 1'b0;
    checks++;
    if (evt_count !== 16'd3) begin fails++; $display("FAIL b2b_evt2: got %0d want 3", evt_count); end
    @(negedge clk);
    force dut.evt_count = 16'hFFFF;
    @(negedge clk);
    release dut.evt_count;
    @(negedge clk);
    Nmax = 8'd1; all_done = 1'b1;
    collect(1'b0, 60, 0, ndone);
    checks++;
    if (got_q.size() != 1 || ndone != 1) begin fails++; $display("FAIL wrap_event: got %0d words want 1", got_q.size()); end
    @(negedge clk); all_done = 1'b0;
    checks++;
    if (evt_count !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h want 0000", evt_count); end
  endtask

  initial begin
    rstb = 1'b1; all_done = 1'b0; jet_ready = 1'b1; Nmax = 8'd0;
    all_done_c = 1'b0; jet_ready_c = 1'b1; Nmax_c = 8'd0;
    #3 rstb = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    repeat (2) @(negedge clk);
    test_backpressure();
    repeat (2) @(negedge clk);
    test_zero();
    repeat (2) @(negedge clk);
    test_clip();
    repeat (2) @(negedge clk);
    test_reset_mid();
    repeat (2) @(negedge clk);
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
